lfsr_prbs_gen_chk: RTL and testbench

Parametrised PRBS generator and self-synchronising checker for UART link test and loopback. The generator emits an OUT_BITS-wide pseudo-random word per valid/ready transfer, advancing a WIDTH-bit Fibonacci LFSR by OUT_BITS steps in one cycle. It supports runtime seed load, all-zero lockup protection and one-shot error injection. The checker locks to a received stream of the same polynomial, counts word errors and drops lock after repeated mismatches.

---
 rtl/lfsr_prbs_gen_chk_pkg.sv | 27 ++
 rtl/lfsr_prbs_gen_chk_if.sv | 32 +++
 rtl/lfsr_prbs_gen_chk_lfsr_step_n.sv | 14 +
 rtl/lfsr_prbs_gen_chk.sv | 141 ++++++++++++++
 tb/tb_lfsr_prbs_gen_chk.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_prbs_gen_chk_pkg.sv
// Shared types and the LFSR advance function used by the PRBS generator and checker.
package lfsr_prbs_gen_chk_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] lfsr_vec_t;

    typedef enum logic {StHunt, StLocked} chk_state_e;

    // Fibonacci LFSR: shift left, new LSB = XOR of tapped bits; repeated `steps` times.
    function automatic lfsr_vec_t lfsr_advance(input lfsr_vec_t   state,
                                               input lfsr_vec_t   taps,
                                               input int unsigned width,
                                               input int unsigned steps);
        lfsr_vec_t s;
        lfsr_vec_t mask;
        s    = state;
        mask = (width >= MAX_WIDTH) ? '1 : ((lfsr_vec_t'(1) << width) - lfsr_vec_t'(1));
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < steps) begin
                s = ((s << 1) | lfsr_vec_t'(^(s & taps & mask))) & mask;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_prbs_gen_chk_if.sv
// Generator handshake, control strobes and checker status for lfsr_prbs_gen_chk.
interface lfsr_prbs_gen_chk_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned OUT_BITS = 8,
    parameter int unsigned ERR_W    = 16
);
    logic                i_Gen_Enable;
    logic                i_Gen_Ready;
    logic                o_Gen_DV;
    logic [OUT_BITS-1:0] o_Gen_Word;
    logic                i_Seed_Load;
    logic [WIDTH-1:0]    i_Seed;
    logic                i_Inject_Err;
    logic                i_Chk_DV;
    logic [OUT_BITS-1:0] i_Chk_Word;
    logic                i_Clear_Errors;
    logic                o_Chk_Locked;
    logic                o_Chk_Err_Pulse;
    logic [ERR_W-1:0]    o_Chk_Err_Count;

    modport master (
        output i_Gen_Enable, i_Gen_Ready, i_Seed_Load, i_Seed, i_Inject_Err,
        output i_Chk_DV, i_Chk_Word, i_Clear_Errors,
        input  o_Gen_DV, o_Gen_Word, o_Chk_Locked, o_Chk_Err_Pulse, o_Chk_Err_Count
    );

    modport slave (
        input  i_Gen_Enable, i_Gen_Ready, i_Seed_Load, i_Seed, i_Inject_Err,
        input  i_Chk_DV, i_Chk_Word, i_Clear_Errors,
        output o_Gen_DV, o_Gen_Word, o_Chk_Locked, o_Chk_Err_Pulse, o_Chk_Err_Count
    );
endinterface

// File: rtl/lfsr_prbs_gen_chk_lfsr_step_n.sv
// Combinational unroller: advances a WIDTH-bit LFSR state by OUT_BITS steps.
module lfsr_step_n
    import lfsr_prbs_gen_chk_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'h8058,
    parameter int unsigned      OUT_BITS = 8
) (
    input  logic [WIDTH-1:0] cur_state,
    output logic [WIDTH-1:0] nxt_state
);
    assign nxt_state = WIDTH'(lfsr_advance(lfsr_vec_t'(cur_state), lfsr_vec_t'(TAPS),
                                           WIDTH, OUT_BITS));
endmodule

// File: rtl/lfsr_prbs_gen_chk.sv
// PRBS word generator with valid/ready output, seed load and error injection, plus a
// self-synchronising checker that locks to a received stream and counts word errors.
module lfsr_prbs_gen_chk
    import lfsr_prbs_gen_chk_pkg::*;
#(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] TAPS        = 16'h8058,
    parameter logic [WIDTH-1:0] SEED        = 16'hACE1,
    parameter int unsigned      OUT_BITS    = 8,
    parameter int unsigned      ERR_W       = 16,
    parameter int unsigned      LOSS_THRESH = 4
) (
    input logic                i_Clock,
    input logic                i_Reset,
    lfsr_prbs_gen_chk_if.slave bus
);
    localparam int unsigned WORDS  = WIDTH / OUT_BITS;
    localparam int unsigned HUNT_W = $clog2(WORDS + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);

    logic [WIDTH-1:0]  gen_state_q, gen_state_d, gen_next;
    logic              gen_dv_q, gen_dv_d;
    logic              inject_q, inject_d;
    logic              gen_xfer;
    logic [WIDTH-1:0]  chk_state_q, chk_state_d, chk_next;
    chk_state_e        fsm_q, fsm_d;
    logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_pulse_q, err_pulse_d;

    lfsr_step_n #(.WIDTH(WIDTH), .TAPS(TAPS), .OUT_BITS(OUT_BITS)) u_gen_step (
        .cur_state (gen_state_q),
        .nxt_state (gen_next)
    );

    lfsr_step_n #(.WIDTH(WIDTH), .TAPS(TAPS), .OUT_BITS(OUT_BITS)) u_chk_step (
        .cur_state (chk_state_q),
        .nxt_state (chk_next)
    );

    assign gen_xfer = gen_dv_q & bus.i_Gen_Ready;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            gen_state_q <= SEED;
            gen_dv_q    <= 1'b0;
            inject_q    <= 1'b0;
            chk_state_q <= '0;
            fsm_q       <= StHunt;
            hunt_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            gen_state_q <= gen_state_d;
            gen_dv_q    <= gen_dv_d;
            inject_q    <= inject_d;
            chk_state_q <= chk_state_d;
            fsm_q       <= fsm_d;
            hunt_cnt_q  <= hunt_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin : gen_next_state
        gen_state_d = gen_state_q;
        if (bus.i_Seed_Load) begin
            gen_state_d = (bus.i_Seed == '0) ? SEED : bus.i_Seed;
        end else if (gen_xfer) begin
            // Non-maximal tap sets could reach zero; fall back to SEED rather than lock up.
            gen_state_d = (gen_next == '0) ? SEED : gen_next;
        end
        // A presented but unaccepted word keeps DV high regardless of enable.
        gen_dv_d = (gen_dv_q & ~bus.i_Gen_Ready) | bus.i_Gen_Enable;
        inject_d = inject_q;
        if (gen_xfer && inject_q) begin
            inject_d = 1'b0;
        end else if (bus.i_Inject_Err) begin
            inject_d = 1'b1;
        end
    end

    always_comb begin : chk_next_state
        fsm_d       = fsm_q;
        chk_state_d = chk_state_q;
        hunt_cnt_d  = hunt_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        if (bus.i_Chk_DV) begin
            unique case (fsm_q)
                StHunt: begin
                    chk_state_d = (chk_state_q << OUT_BITS) | WIDTH'(bus.i_Chk_Word);
                    hunt_cnt_d  = hunt_cnt_q + HUNT_W'(1);
                    if (hunt_cnt_d == HUNT_W'(WORDS)) begin
                        fsm_d      = StLocked;
                        hunt_cnt_d = '0;
                        miss_cnt_d = '0;
                    end
                end
                StLocked: begin
                    if (chk_state_q == '0) begin
                        fsm_d      = StHunt;
                        hunt_cnt_d = '0;
                        miss_cnt_d = '0;
                    end else begin
                        // Track the prediction, not the received word, so one bad word
                        // costs exactly one error.
                        chk_state_d = chk_next;
                        if (bus.i_Chk_Word != chk_next[OUT_BITS-1:0]) begin
                            err_pulse_d = 1'b1;
                            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                            if (miss_cnt_d == MISS_W'(LOSS_THRESH)) begin
                                fsm_d      = StHunt;
                                hunt_cnt_d = '0;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            miss_cnt_d = '0;
                        end
                    end
                end
                default: fsm_d = StHunt;
            endcase
        end
        if (bus.i_Clear_Errors) err_cnt_d = '0;
    end

    always_comb begin : outputs
        bus.o_Gen_DV        = gen_dv_q;
        bus.o_Gen_Word      = gen_state_q[OUT_BITS-1:0] ^ OUT_BITS'(inject_q);
        bus.o_Chk_Locked    = (fsm_q == StLocked);
        bus.o_Chk_Err_Pulse = err_pulse_q;
        bus.o_Chk_Err_Count = err_cnt_q;
    end

endmodule

// File: tb/tb_lfsr_prbs_gen_chk.sv
// Directed and randomized bench for lfsr_prbs_gen_chk against a bit-sequence reference model.
module tb_lfsr_prbs_gen_chk;
    localparam int unsigned      WIDTH       = 16;
    localparam int unsigned      OUT_BITS    = 8;
    localparam int unsigned      ERR_W       = 16;
    localparam int unsigned      LOSS_THRESH = 4;
    localparam logic [WIDTH-1:0] TAPS        = 16'h8058;
    localparam logic [WIDTH-1:0] SEED        = 16'hACE1;
    localparam int unsigned      CNT_MAX     = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_prbs_gen_chk_if #(.WIDTH(WIDTH), .OUT_BITS(OUT_BITS), .ERR_W(ERR_W)) bus ();

    lfsr_prbs_gen_chk #(
        .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .OUT_BITS(OUT_BITS),
        .ERR_W(ERR_W), .LOSS_THRESH(LOSS_THRESH)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference: PRBS as a bit sequence b[k] = XOR over taps t of b[k-1-t], oldest bit first.
    bit          gen_q[$];
    bit          chk_q[$];
    bit          m_dv, m_inj, m_locked, m_pulse;
    int          m_hunt, m_miss;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit next_bit(input bit q[$]);
        bit b = 1'b0;
        for (int t = 0; t < WIDTH; t++) if (TAPS[t]) b ^= q[q.size()-1-t];
        return b;
    endfunction

    function automatic logic [OUT_BITS-1:0] low_word(input bit q[$]);
        logic [OUT_BITS-1:0] w;
        for (int i = 0; i < OUT_BITS; i++) w[i] = q[q.size()-1-i];
        return w;
    endfunction

    task automatic gen_load(input logic [WIDTH-1:0] s);
        gen_q.delete();
        for (int i = WIDTH - 1; i >= 0; i--) gen_q.push_back(s[i]);
    endtask

    task automatic gen_push();
        for (int i = 0; i < OUT_BITS; i++) gen_q.push_back(next_bit(gen_q));
        while (gen_q.size() > WIDTH) void'(gen_q.pop_front());
    endtask

    task automatic chk_push_bits(input logic [OUT_BITS-1:0] w);
        for (int i = OUT_BITS - 1; i >= 0; i--) chk_q.push_back(w[i]);
        while (chk_q.size() > WIDTH) void'(chk_q.pop_front());
    endtask

    task automatic chk_push_pred();
        for (int i = 0; i < OUT_BITS; i++) chk_q.push_back(next_bit(chk_q));
        while (chk_q.size() > WIDTH) void'(chk_q.pop_front());
    endtask

    task automatic model_reset();
        gen_load(SEED);
        chk_q.delete();
        for (int i = 0; i < WIDTH; i++) chk_q.push_back(1'b0);
        m_dv = 0; m_inj = 0; m_locked = 0; m_pulse = 0;
        m_hunt = 0; m_miss = 0; m_cnt = 0;
    endtask

    task automatic drive_idle();
        bus.i_Gen_Enable = 0; bus.i_Gen_Ready = 0; bus.i_Seed_Load = 0; bus.i_Seed = '0;
        bus.i_Inject_Err = 0; bus.i_Chk_DV = 0; bus.i_Chk_Word = '0; bus.i_Clear_Errors = 0;
    endtask

    // Update the model from the inputs now driven, clock once, then compare every output.
    task automatic cycle(input string tag);
        bit                  xfer;
        bit                  allz;
        logic [OUT_BITS-1:0] pred;
        xfer = m_dv & bus.i_Gen_Ready;
        if (bus.i_Seed_Load) gen_load((bus.i_Seed == '0) ? SEED : bus.i_Seed);
        else if (xfer) gen_push();
        if (xfer && m_inj) m_inj = 0;
        else if (bus.i_Inject_Err) m_inj = 1;
        m_dv = (m_dv & ~bus.i_Gen_Ready) | bus.i_Gen_Enable;
        m_pulse = 0;
        if (bus.i_Chk_DV) begin
            if (!m_locked) begin
                chk_push_bits(bus.i_Chk_Word);
                m_hunt++;
                if (m_hunt == WIDTH / OUT_BITS) begin
                    m_locked = 1; m_hunt = 0; m_miss = 0;
                end
            end else begin
                allz = 1;
                foreach (chk_q[i]) if (chk_q[i]) allz = 0;
                if (allz) begin
                    m_locked = 0; m_hunt = 0; m_miss = 0;
                end else begin
                    chk_push_pred();
                    pred = low_word(chk_q);
                    if (bus.i_Chk_Word != pred) begin
                        m_pulse = 1;
                        if (m_cnt != CNT_MAX) m_cnt++;
                        m_miss++;
                        if (m_miss == LOSS_THRESH) begin
                            m_locked = 0; m_hunt = 0; m_miss = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            end
        end
        if (bus.i_Clear_Errors) m_cnt = 0;
        @(posedge clk);
        #1;
        chk({tag, "/dv"}, 32'(bus.o_Gen_DV), 32'(m_dv));
        chk({tag, "/word"}, 32'(bus.o_Gen_Word), 32'(low_word(gen_q) ^ OUT_BITS'(m_inj)));
        chk({tag, "/locked"}, 32'(bus.o_Chk_Locked), 32'(m_locked));
        chk({tag, "/pulse"}, 32'(bus.o_Chk_Err_Pulse), 32'(m_pulse));
        chk({tag, "/count"}, 32'(bus.o_Chk_Err_Count), m_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/dv"}, 32'(bus.o_Gen_DV), 32'd0);
        chk({tag, "/word"}, 32'(bus.o_Gen_Word), 32'(SEED[OUT_BITS-1:0]));
        chk({tag, "/locked"}, 32'(bus.o_Chk_Locked), 32'd0);
        chk({tag, "/pulse"}, 32'(bus.o_Chk_Err_Pulse), 32'd0);
        chk({tag, "/count"}, 32'(bus.o_Chk_Err_Count), 32'd0);
    endtask

    // One loopback cycle: random ready, checker sees each transferred generator word.
    task automatic loop_cycle(input string tag, output bit xfer);
        bus.i_Gen_Enable = 1;
        bus.i_Gen_Ready  = ($urandom_range(0, 3) != 0);
        xfer             = m_dv & bus.i_Gen_Ready;
        bus.i_Chk_DV     = xfer;
        bus.i_Chk_Word   = bus.o_Gen_Word;
        cycle(tag);
    endtask

    initial begin
        int  xfers;
        int  cycles;
        int  pulses;
        bit  x;

        drive_idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;

        // First word, held under backpressure, then the next word on ready.
        bus.i_Gen_Enable = 1;
        cycle("first");
        chk("first_e1", 32'(bus.o_Gen_Word), 32'h0000_00E1);
        for (int i = 0; i < 5; i++) begin
            cycle("hold");
            chk("hold_e1", 32'(bus.o_Gen_Word), 32'h0000_00E1);
        end
        bus.i_Gen_Ready = 1;
        cycle("second");
        chk("second_72", 32'(bus.o_Gen_Word), 32'h0000_0072);
        cycle("third");

        // Seed load: zero recovers SEED, non-zero loads directly.
        bus.i_Gen_Ready = 0;
        bus.i_Seed_Load = 1;
        bus.i_Seed      = '0;
        cycle("seed0");
        chk("seed0_e1", 32'(bus.o_Gen_Word), 32'h0000_00E1);
        bus.i_Seed = 16'h1234;
        cycle("seed1234");
        chk("seed_34", 32'(bus.o_Gen_Word), 32'h0000_0034);
        bus.i_Seed_Load = 0;

        // Loopback: lock after two words, then 1000 error-free words.
        xfers = 0; cycles = 0;
        while (xfers < 1000 && cycles < 5000) begin
            loop_cycle("loop", x);
            if (x) xfers++;
            cycles++;
            if (xfers == 2 && x) chk("lock_after_2", 32'(bus.o_Chk_Locked), 32'd1);
        end
        chk("loop_xfers", 32'(xfers), 32'd1000);
        chk("loop_count0", 32'(bus.o_Chk_Err_Count), 32'd0);
        chk("loop_locked", 32'(bus.o_Chk_Locked), 32'd1);

        // Single injected error: one pulse, count 1, lock held, then clear.
        bus.i_Inject_Err = 1;
        loop_cycle("inj", x);
        bus.i_Inject_Err = 0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            loop_cycle("inj_run", x);
            if (bus.o_Chk_Err_Pulse) pulses++;
        end
        chk("inj_pulses", 32'(pulses), 32'd1);
        chk("inj_count", 32'(bus.o_Chk_Err_Count), 32'd1);
        chk("inj_locked", 32'(bus.o_Chk_Locked), 32'd1);
        drive_idle();
        bus.i_Clear_Errors = 1;
        cycle("clear");
        chk("clear_count", 32'(bus.o_Chk_Err_Count), 32'd0);
        bus.i_Clear_Errors = 0;

        // Constant 0x55 stream drops lock; further words in HUNT are not counted.
        bus.i_Chk_DV   = 1;
        bus.i_Chk_Word = 8'h55;
        cycles = 0;
        while (m_locked && cycles < 16) begin
            cycle("c55");
            cycles++;
        end
        chk("c55_unlocked", 32'(bus.o_Chk_Locked), 32'd0);
        cycle("c55_hunt");
        chk("c55_hunt_pulse", 32'(bus.o_Chk_Err_Pulse), 32'd0);
        bus.i_Chk_DV = 0;

        // Randomized mix of every input.
        for (int i = 0; i < 600; i++) begin
            bus.i_Gen_Enable   = $urandom_range(0, 1);
            bus.i_Gen_Ready    = $urandom_range(0, 1);
            bus.i_Seed_Load    = ($urandom_range(0, 15) == 0);
            bus.i_Seed         = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            bus.i_Inject_Err   = ($urandom_range(0, 15) == 0);
            bus.i_Chk_DV       = $urandom_range(0, 1);
            bus.i_Chk_Word     = ($urandom_range(0, 3) != 0) ? bus.o_Gen_Word
                                                             : OUT_BITS'($urandom);
            bus.i_Clear_Errors = ($urandom_range(0, 31) == 0);
            cycle("rand");
        end

        // Reset mid-stream, away from any clock edge.
        for (int i = 0; i < 10; i++) loop_cycle("pre_rst", x);
        #3 rst = 1;
        #1;
        check_reset_outputs("async_rst");
        drive_idle();
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        cycle("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
